// File: rtl/soc_top_pkg.sv
// soc_top_pkg: shared definitions for the ROM-scripted GPIO sequencer.
//   - opcode and FSM state enums
//   - instruction field positions and the packed instruction struct
//   - the default 16-word program image (PROG_ROM) and a helper to encode words
package soc_top_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 14;
  localparam int IMM_MSB    = 13;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;
  localparam int ROM_WORDS  = 16;

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_DELAY = 2'b01,
    OP_ROTL  = 2'b10,
    OP_JUMP  = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } state_e;

  typedef struct packed {
    opcode_e          opcode;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef logic [ROM_WORDS-1:0][INSTR_W-1:0] rom_image_t;

  function automatic logic [INSTR_W-1:0] mk_instr(opcode_e op, logic [IMM_W-1:0] imm);
    instr_t i;
    i.opcode = op;
    i.imm    = imm;
    return i;
  endfunction

  // Default program: light bit 0, then rotate it once every 12 cycles forever.
  // Unused words jump back into the loop so a stray pc cannot run off.
  function automatic rom_image_t default_prog();
    rom_image_t p;
    for (int i = 0; i < ROM_WORDS; i++) begin
      p[i] = mk_instr(OP_JUMP, 14'd1);
    end
    p[0] = mk_instr(OP_SET,   14'h01);
    p[1] = mk_instr(OP_DELAY, 14'd9);
    p[2] = mk_instr(OP_ROTL,  14'd0);
    p[3] = mk_instr(OP_JUMP,  14'd1);
    return p;
  endfunction

  localparam rom_image_t PROG_ROM = default_prog();

  // Word returned for addresses past the end of the stored image.
  localparam logic [INSTR_W-1:0] FILL_WORD = {OP_JUMP, 14'd1};

endpackage

// File: rtl/seq_rom.sv
// seq_rom: combinational program ROM for the GPIO sequencer.
//   PROG_DEPTH  number of addressable words (power of two)
//   PROG_IMAGE  program contents, defaults to soc_top_pkg::PROG_ROM
// Ports:
//   addr   in   log2(PROG_DEPTH)  word address (the pc)
//   instr  out  16                instruction word at addr
module seq_rom
  import soc_top_pkg::*;
#(
  parameter int         PROG_DEPTH = 16,
  parameter rom_image_t PROG_IMAGE = PROG_ROM,
  localparam int        PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] instr
);

  // The stored image holds ROM_WORDS words; a deeper ROM reads FILL_WORD
  // above that, a shallower one simply never reaches the upper words.
  if (PROG_DEPTH <= ROM_WORDS) begin : g_direct
    assign instr = PROG_IMAGE[addr];
  end else begin : g_filled
    always_comb begin
      instr = FILL_WORD;
      if (addr < PC_W'(ROM_WORDS)) begin
        instr = PROG_IMAGE[addr[$clog2(ROM_WORDS)-1:0]];
      end
    end
  end

endmodule

// File: rtl/soc_top.sv
// soc_top: minimal SoC top, a ROM-scripted sequencer driving an 8-bit GPIO bank.
//   PROG_DEPTH  ROM words (power of two), pc width is log2(PROG_DEPTH)
//   DELAY_W     width of the DELAY immediate used and of the delay counter
//   PROG_IMAGE  program contents (defaults to the package PROG_ROM)
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous active-high reset
//   gpio   out  8  GPIO pins, straight from gpio_q
// Build option SOC_TOP_GPIO_ACTIVE_LOW_EN: pins drive ~gpio_q (0xFF in reset);
// the program still operates on the true-polarity register.
module soc_top
  import soc_top_pkg::*;
#(
  parameter int         PROG_DEPTH = 16,
  parameter int         DELAY_W    = 14,
  parameter rom_image_t PROG_IMAGE = PROG_ROM
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] gpio
);

  localparam int PC_W = $clog2(PROG_DEPTH);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [7:0]         gpio_q, gpio_d;
  logic [INSTR_W-1:0] rom_word;
  instr_t             instr;
  logic [PC_W-1:0]    pc_inc;

  seq_rom #(
    .PROG_DEPTH (PROG_DEPTH),
    .PROG_IMAGE (PROG_IMAGE)
  ) u_rom (
    .addr  (pc_q),
    .instr (rom_word)
  );

  assign instr  = instr_t'(rom_word);
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    delay_cnt_d = delay_cnt_q;
    gpio_d      = gpio_q;
    case (state_q)
      ST_FETCH: begin
        case (instr.opcode)
          OP_SET: begin
            gpio_d = instr.imm[7:0];
            pc_d   = pc_inc;
          end
          OP_DELAY: begin
            // DELAY 0 is a one-cycle no-op; otherwise the WAIT state
            // burns the remaining n cycles.
            if (instr.imm[DELAY_W-1:0] == '0) begin
              pc_d = pc_inc;
            end else begin
              delay_cnt_d = instr.imm[DELAY_W-1:0];
              state_d     = ST_WAIT;
            end
          end
          OP_ROTL: begin
            gpio_d = {gpio_q[6:0], gpio_q[7]};
            pc_d   = pc_inc;
          end
          OP_JUMP: begin
            pc_d = instr.imm[PC_W-1:0];
          end
          default: pc_d = pc_inc;
        endcase
      end
      ST_WAIT: begin
        // The edge that sees a count of 1 is the last cycle of the delay.
        if (delay_cnt_q == DELAY_W'(1)) begin
          delay_cnt_d = '0;
          pc_d        = pc_inc;
          state_d     = ST_FETCH;
        end else begin
          delay_cnt_d = delay_cnt_q - DELAY_W'(1);
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      delay_cnt_q <= '0;
      gpio_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      delay_cnt_q <= delay_cnt_d;
      gpio_q      <= gpio_d;
    end
  end

`ifdef SOC_TOP_GPIO_ACTIVE_LOW_EN
  assign gpio = ~gpio_q;
`else
  assign gpio = gpio_q;
`endif

endmodule

// File: tb/tb_soc_top.sv
// tb_soc_top: self-checking bench for soc_top.
// dut_a runs the default program; dut_b runs a DELAY-0 / pc-wrap program.
// Each cycle's expected pin value is queued when the cycle is driven and
// popped and compared 1 time unit after the rising edge.
module tb_soc_top;
  import soc_top_pkg::*;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    bit         sel;
  } sb_item_t;

  function automatic rom_image_t build_prog_b();
    rom_image_t p;
    for (int i = 0; i < ROM_WORDS; i++) begin
      p[i] = mk_instr(OP_ROTL, 14'd0);
    end
    p[0] = mk_instr(OP_SET,   14'h0A5);
    p[1] = mk_instr(OP_DELAY, 14'd0);
    return p;
  endfunction

  localparam rom_image_t PROG_B = build_prog_b();

  logic       clk;
  logic       reset_a;
  logic       reset_b;
  logic [7:0] gpio_a;
  logic [7:0] gpio_b;

  int tests_run;
  int tests_failed;
  sb_item_t sb_q[$];

  soc_top dut_a (
    .clk   (clk),
    .reset (reset_a),
    .gpio  (gpio_a)
  );

  soc_top #(
    .PROG_IMAGE (PROG_B)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .gpio  (gpio_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_pins(logic [7:0] v);
`ifdef SOC_TOP_GPIO_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) begin
      r = {r[6:0], r[7]};
    end
    return r;
  endfunction

  // Default program: 0x01 from E0, first rotate at E11, then every 12 edges.
  function automatic logic [7:0] exp_default(int k);
    int step;
    if (k < 11) begin
      return 8'h01;
    end
    step = 1 + (k - 11) / 12;
    return rotl8(8'h01, step % 8);
  endfunction

  // Program B: 16-edge loop, SET at 0, DELAY 0 at 1, rotate every edge after.
  function automatic logic [7:0] exp_prog_b(int k);
    int m;
    m = k % 16;
    if (m < 2) begin
      return 8'hA5;
    end
    return rotl8(8'hA5, m - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_a, input logic rst_b, input bit sel,
                               input string tag, input logic [7:0] exp_reg);
    sb_item_t it;
    sb_item_t got_it;
    reset_a = rst_a;
    reset_b = rst_b;
    it.tag  = tag;
    it.exp  = to_pins(exp_reg);
    it.sel  = sel;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    got_it = sb_q.pop_front();
    checkOutput(got_it.tag, {24'd0, (got_it.sel ? gpio_b : gpio_a)}, {24'd0, got_it.exp});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_a      = 1'b1;
    reset_b      = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, $sformatf("a_reset%0d", i), 8'h00);
    end

    for (int k = 0; k < 120; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, $sformatf("a_run_E%0d", k), exp_default(k));
    end

    applyStimulus(1'b1, 1'b1, 1'b0, "a_reset_mid_prog", 8'h00);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, $sformatf("a_pre_E%0d", k), exp_default(k));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, "a_reset_mid_delay", 8'h00);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, $sformatf("a_restart_E%0d", k), exp_default(k));
    end

    applyStimulus(1'b1, 1'b1, 1'b1, "b_reset", 8'h00);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, $sformatf("b_run_E%0d", k), exp_prog_b(k));
    end

    checkOutput("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Minimal SoC top driving an 8-bit GPIO bank from a built-in, ROM-scripted sequencer. No external bus.
- A small program ROM of 16-bit commands is stepped by a control FSM. Commands set, rotate or hold the GPIO output register, or jump.
- Used as the simulation and bring-up top: clock and reset in, LEDs/pins out.

Parameters:
- PROG_DEPTH, 16, number of ROM words; a power of two; PC width is log2(PROG_DEPTH).
- DELAY_W, 14, width of the DELAY immediate and of the delay counter.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- gpio  output  8  GPIO pins, driven directly from a register (no combinational path).

Behaviour:
- Instruction word is 16 bits:
  - [15:14] = opcode; [13:0] = immediate.
  - 00 SET: gpio_reg <= imm[7:0].
  - 01 DELAY: hold for imm+1 cycles total.
  - 10 ROTL: gpio_reg <= {gpio_reg[6:0], gpio_reg[7]}.
  - 11 JUMP: pc <= imm[log2(PROG_DEPTH)-1:0].
- Reset, while reset=1 at an edge:
  - pc=0, gpio_reg=0x00, delay_cnt=0, state=FETCH.
  - Reset asserted mid-DELAY or mid-program aborts immediately. The first instruction executes at the first edge with reset=0.
- FSM states:
  - FETCH/EXEC: one instruction per edge.
  - WAIT: DELAY in progress.
- Non-DELAY opcodes:
  - Complete in 1 cycle.
  - The gpio_reg update is visible on gpio right after that edge.
  - pc <= pc+1, except JUMP.
- DELAY n:
  - At the exec edge, load delay_cnt=n and go to WAIT. If n=0, stay in EXEC and do pc+1: one cycle total.
  - In WAIT, decrement each edge. At the edge where delay_cnt==1, do pc+1 and return to EXEC.
  - Total cycles occupied = n+1.
- pc wrap: pc+1 from PROG_DEPTH-1 wraps to 0.
- JUMP: a target out of range is truncated to pc width. JUMP to self is a legal halt.
- ROM contents: combinational read of a package constant, 16-bit words. Default program:
  - addr0 SET 0x01.
  - addr1 DELAY 9.
  - addr2 ROTL.
  - addr3 JUMP 1.
  - All remaining words = JUMP 1.
- Default timing, edges counted from the first post-reset edge E0:
  - E0: gpio=0x01.
  - E1..E10: delay.
  - E11: gpio=0x02.
  - E12: jump.
  - E13..E22: delay.
  - E23: gpio=0x04.
  - Steady period: 12 cycles per step. Wraps 0x80 -> 0x01.
- gpio holds its value between updates and during WAIT.

Optional Feature:
- Macro SOC_TOP_GPIO_ACTIVE_LOW_EN.
- Defined:
  - Pins are inverted: gpio = ~gpio_reg. Pins read 0xFF in reset.
  - Internal semantics are unchanged: ROTL and SET act on gpio_reg.
- Undefined: gpio = gpio_reg.

Decomposition:
- Package soc_top_pkg:
  - Opcode enum (OP_SET, OP_DELAY, OP_ROTL, OP_JUMP).
  - Field position constants.
  - Instruction typedef (struct: opcode, imm).
  - Default PROG_ROM constant array.
- One sub-module, seq_rom:
  - Parameterized by PROG_DEPTH.
  - Input: address. Output: 16-bit instruction from the package constant.
- FSM, pc, delay counter and gpio_reg live in soc_top.

Test Plan:
- Reset release: hold reset 5 cycles -> gpio=0x00 throughout. Release -> gpio=0x01 after E0, stays 0x01 through E10.
- Rotation cadence: run 100 cycles -> gpio steps 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80 at E0,E11,E23,E35,E47,E59,E71,E83.
- Wrap: continue -> 0x80 rotates to 0x01 at E95. Period remains exactly 12 cycles.
- Reset mid-DELAY: assert reset at E5 for 1 cycle -> gpio=0x00 immediately after that edge. Then 0x01 at the first edge after release, and the next rotate comes 11 cycles later.
- DELAY 0 and pc wrap: override ROM {SET 0xA5, DELAY 0, ROTL, then 13 ROTL words} -> 0xA5, then a rotate every cycle from the third cycle. pc wraps 15 -> 0 and re-executes SET 0xA5.
- Active-low build: SOC_TOP_GPIO_ACTIVE_LOW_EN defined -> gpio=0xFF in reset, 0xFE after E0, 0xFD after E11.
